bist_signature_analyzer: RTL and testbench

- MISR-based response compactor sitting directly downstream of the scan-wrapped circuit under test in the BIST top level.
- Each capture cycle folds the CUT's parallel outputs and scan_out into a multiple-input signature register.
- On test end it compares the signature against a golden constant and drives the pass_nfail verdict plus a done flag back to the BIST controller.

---
 rtl/bist_signature_analyzer.sv | 113 +++++++++++
 tb/tb_bist_signature_analyzer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_signature_analyzer.sv
// MISR response compactor with golden-signature verdict for the BIST top level.
// Define BIST_SIG_XMASK_EN to add the x_mask input that blanks unknown CUT bits.
module bist_signature_analyzer #(
    parameter int unsigned      WIDTH  = 10,
    parameter logic [WIDTH-1:0] POLY   = 10'h009,
    parameter logic [WIDTH-1:0] SEED   = 10'h000,
    parameter logic [WIDTH-1:0] GOLDEN = 10'h000,
    parameter int unsigned      CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             capture,
    input  logic [WIDTH-1:0] data_in,
`ifdef BIST_SIG_XMASK_EN
    input  logic [WIDTH-1:0] x_mask,
`endif
    input  logic             finish,
    output logic             busy,
    output logic             done,
    output logic             pass_nfail,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] cap_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CMP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state;
    logic [WIDTH-1:0] fold;
    logic [WIDTH-1:0] misr_next;
    logic [CNT_W-1:0] cnt_next;

    // data_in is gated by capture so an idle/X bus never reaches the MISR
    always_comb begin
        fold = '0;
        if (capture) begin
`ifdef BIST_SIG_XMASK_EN
            fold = data_in & ~x_mask;
`else
            fold = data_in;
`endif
        end
        misr_next = {signature[WIDTH-2:0], 1'b0}
                  ^ (signature[WIDTH-1] ? POLY : '0)
                  ^ fold;
        cnt_next = (&cap_count) ? cap_count : cap_count + CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            signature  <= '0;
            cap_count  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass_nfail <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        signature <= SEED;
                        cap_count <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        signature <= SEED;
                        cap_count <= '0;
                    end else begin
                        if (capture) begin
                            signature <= misr_next;
                            cap_count <= cnt_next;
                        end
                        if (finish) begin
                            state <= S_CMP;
                        end
                    end
                end
                S_CMP: begin
                    pass_nfail <= (signature == GOLDEN);
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (start) begin
                        state      <= S_RUN;
                        signature  <= SEED;
                        cap_count  <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass_nfail <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Scoreboarded random bench for bist_signature_analyzer.
// Honours BIST_SIG_XMASK_EN when the design is built with it.
module tb_bist_signature_analyzer;

    localparam int unsigned W      = 10;
    localparam int unsigned CW     = 4;
    localparam logic [9:0]  POLY   = 10'h009;
    localparam logic [9:0]  SEED   = 10'h000;
    localparam logic [9:0]  GOLDEN = 10'h3F3;

    typedef struct {
        logic [9:0] sig;
        logic [3:0] cnt;
        logic       pass;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          capture = 1'b0;
    logic          finish = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  x_mask = '0;
    logic          busy;
    logic          done;
    logic          pass_nfail;
    logic [W-1:0]  signature;
    logic [CW-1:0] cap_count;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [9:0] m_sig;
    logic [3:0] m_cnt;

    bist_signature_analyzer #(
        .WIDTH (W),
        .POLY  (POLY),
        .SEED  (SEED),
        .GOLDEN(GOLDEN),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .capture   (capture),
        .data_in   (data_in),
`ifdef BIST_SIG_XMASK_EN
        .x_mask    (x_mask),
`endif
        .finish    (finish),
        .busy      (busy),
        .done      (done),
        .pass_nfail(pass_nfail),
        .signature (signature),
        .cap_count (cap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Signature as a polynomial: multiply by x, reduce mod x^10+x^3+1, add data
    function automatic logic [9:0] model_fold(input logic [9:0] s,
                                              input logic [9:0] d);
        int unsigned v;
        v = 32'(s) * 2;
        if (v >= 1024) v = v ^ (1024 + 32'(POLY));
        return 10'(v) ^ d;
    endfunction

    function automatic logic [9:0] eff_data(input logic [9:0] d,
                                            input logic [9:0] m);
`ifdef BIST_SIG_XMASK_EN
        return d & ~m;
`else
        if (m == 10'h3FF) return d;
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        data_in = 10'($urandom);
        tick();
        start = 1'b0;
        m_sig = SEED;
        m_cnt = 0;
        chk("start_busy", 32'(busy), 1);
        chk("start_done", 32'(done), 0);
        chk("start_pass", 32'(pass_nfail), 0);
        chk("start_sig", 32'(signature), 32'(SEED));
        chk("start_cnt", 32'(cap_count), 0);
    endtask

    task automatic do_capture(input logic [9:0] w, input logic [9:0] m);
        capture = 1'b1;
        data_in = w;
        x_mask = m;
        tick();
        capture = 1'b0;
        data_in = 10'($urandom);
        x_mask = 10'($urandom);
        m_sig = model_fold(m_sig, eff_data(w, m));
        if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        chk("cap_sig", 32'(signature), 32'(m_sig));
        chk("cap_cnt", 32'(cap_count), 32'(m_cnt));
    endtask

    task automatic do_idle();
        capture = 1'b0;
        data_in = 10'($urandom);
        tick();
        chk("idle_sig", 32'(signature), 32'(m_sig));
    endtask

    task automatic do_finish(input bit with_cap, input logic [9:0] w);
        exp_t e;
        finish = 1'b1;
        capture = with_cap;
        data_in = w;
        x_mask = '0;
        tick();
        finish = 1'b0;
        capture = 1'b0;
        if (with_cap) begin
            m_sig = model_fold(m_sig, w);
            if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        end
        e.sig = m_sig;
        e.cnt = m_cnt;
        e.pass = (m_sig == GOLDEN);
        sb.push_back(e);
        chk("cmp_busy", 32'(busy), 1);
        chk("cmp_done", 32'(done), 0);
        tick();
        chk("done_latency", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
    endtask

    // Monitor: each rising done is one verdict to score
    initial begin : monitor
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_q = 1'b0;
            end else begin
                if (done && !done_q) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_sig", 32'(signature), 32'(e.sig));
                        chk("sb_cnt", 32'(cap_count), 32'(e.cnt));
                        chk("sb_pass", 32'(pass_nfail), 32'(e.pass));
                    end
                end
                done_q = done;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [9:0] held;
        m_sig = '0;
        m_cnt = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // capture/finish ignored in IDLE
        for (int i = 0; i < 4; i++) begin
            capture = 1'b1;
            finish = 1'b1;
            data_in = 10'($urandom);
            tick();
            chk("idle_busy", 32'(busy), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_sig", 32'(signature), 0);
            chk("idle_cnt", 32'(cap_count), 0);
        end
        capture = 1'b0;
        finish = 1'b0;

        // asynchronous reset in the middle of a run
        do_start();
        do_capture(10'h2A5, 10'h000);
        do_capture(10'h15A, 10'h000);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_sig", 32'(signature), 0);
        chk("rst_cnt", 32'(cap_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass_nfail), 0);
        tick();
        rst_n = 1'b1;
        m_sig = '0;
        m_cnt = '0;
        tick();
        chk("post_rst_busy", 32'(busy), 0);

        // golden match
        do_start();
        do_capture(10'h001, 10'h000);
        chk("gold_s1", 32'(signature), 32'h001);
        do_capture(10'h3FF, 10'h000);
        chk("gold_s2", 32'(signature), 32'h3FD);
        do_capture(10'h000, 10'h000);
        chk("gold_s3", 32'(signature), 32'h3F3);
        do_finish(1'b0, 10'h000);
        chk("gold_pass", 32'(pass_nfail), 1);

        // DONE holds while capture/finish toggle
        held = signature;
        for (int i = 0; i < 3; i++) begin
            capture = 1'b1;
            finish = 1'b1;
            data_in = 10'($urandom);
            tick();
            chk("hold_done", 32'(done), 1);
            chk("hold_pass", 32'(pass_nfail), 1);
            chk("hold_sig", 32'(signature), 32'(held));
        end
        capture = 1'b0;
        finish = 1'b0;

        // mismatch; start from DONE clears done and pass
        do_start();
        do_capture(10'h001, 10'h000);
        do_capture(10'h3FE, 10'h000);
        do_capture(10'h000, 10'h000);
        chk("miss_sig", 32'(signature), 32'h3F1);
        do_finish(1'b0, 10'h000);
        chk("miss_pass", 32'(pass_nfail), 0);

        // capture together with finish is still folded
        do_start();
        do_finish(1'b1, 10'h001);
        chk("capfin_sig", 32'(signature), 32'h001);
        chk("capfin_cnt", 32'(cap_count), 1);

        // start beats finish and capture in RUN
        do_start();
        do_capture(10'h155, 10'h000);
        start = 1'b1;
        finish = 1'b1;
        capture = 1'b1;
        data_in = 10'h3C3;
        tick();
        start = 1'b0;
        finish = 1'b0;
        capture = 1'b0;
        m_sig = SEED;
        m_cnt = 0;
        chk("prio_sig", 32'(signature), 32'(SEED));
        chk("prio_cnt", 32'(cap_count), 0);
        chk("prio_busy", 32'(busy), 1);
        tick();
        chk("prio_done", 32'(done), 0);
        chk("prio_run", 32'(busy), 1);
        do_finish(1'b0, 10'h000);

        // counter saturation
        do_start();
        for (int i = 0; i < 20; i++) do_capture(10'($urandom), 10'h000);
        chk("sat_cnt", 32'(cap_count), 15);
        do_finish(1'b0, 10'h000);

`ifdef BIST_SIG_XMASK_EN
        // fully masked captures only shift the register
        do_start();
        do_capture(10'h201, 10'h000);
        chk("xm_seed", 32'(signature), 32'h201);
        do_capture(10'($urandom), 10'h3FF);
        chk("xm_shift1", 32'(signature), 32'h00B);
        do_capture(10'($urandom), 10'h3FF);
        chk("xm_shift2", 32'(signature), 32'h016);
        do_finish(1'b0, 10'h000);
`endif

        // random sessions
        for (int s = 0; s < 40; s++) begin
            int n;
            do_start();
            n = $urandom_range(0, 24);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 9))
                    0, 1: do_idle();
                    2: if ($urandom_range(0, 3) == 0) do_start();
                       else do_idle();
                    default: do_capture(10'($urandom), 10'($urandom));
                endcase
            end
            do_finish(1'($urandom), 10'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
